// File: rtl/ingress_pkg.sv
// Shared types and default widths for the ingress framer.
// The structs are shaped for the default widths; modules with
// overridden widths declare matching local types with the same field order.
package ingress_pkg;

  localparam int DEF_DATA_W     = 16;
  localparam int DEF_PORT_W     = 4;
  localparam int DEF_PRI_W      = 3;
  localparam int DEF_LEN_W      = 9;
  localparam int DEF_PAGE_WORDS = 8;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_BODY = 2'd2,
    ST_DROP = 2'd3
  } ingress_state_t;

  // Header layout inside the low bits of the header beat (port lowest).
  typedef struct packed {
    logic [DEF_LEN_W-1:0]  len;
    logic [DEF_PRI_W-1:0]  prior;
    logic [DEF_PORT_W-1:0] port;
  } ingress_hdr_t;

  // One framed FIFO entry: beat data plus framing tags.
  typedef struct packed {
    logic [DEF_DATA_W-1:0] data;
    logic                  first;
    logic                  last;
    logic                  page_first;
    logic                  err;
  } ingress_entry_t;

endpackage

// File: rtl/ingress_fifo.sv
// First-word fall-through FIFO, parametrised by entry type and depth.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
// Storage is not reset; the head is forced to zero while the FIFO is empty.
module ingress_fifo #(
  parameter type entry_t = logic,
  parameter int  DEPTH   = 4
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   push,
  input  entry_t                 push_entry,
  input  logic                   pop_rdy,
  output logic                   full,
  output logic                   head_vld,
  output entry_t                 head,
  output logic [$clog2(DEPTH):0] cnt
);

  localparam int AW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop;
  logic          do_push;

  assign head_vld = (cnt != '0);
  assign full     = (cnt == (AW+1)'(DEPTH));
  assign pop      = head_vld && pop_rdy;
  assign do_push  = push && (!full || pop);
  assign head     = head_vld ? mem[rd_ptr] : '0;

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // Entry storage write.
  always_ff @(posedge sys_clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/ingress_framer.sv
// Ingress framer: turns the sop/vld/eop beat stream into tagged FIFO entries.
// Optional feature macro: INGRESS_LEN_CHECK_EN enables the declared-length
// check and the err_len pulse; without it err_len is 0 and err comes only from
// overflow or abort.
// Output handshake: an entry transfers in every cycle where out_vld and out_rdy
// are both high; out_vld never depends on out_rdy, and the head entry stays
// stable until it is popped.
module ingress_framer
  import ingress_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int PORT_W     = DEF_PORT_W,
  parameter int PRI_W      = DEF_PRI_W,
  parameter int LEN_W      = DEF_LEN_W,
  parameter int PAGE_WORDS = DEF_PAGE_WORDS,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst,
  input  logic                        wr_sop,
  input  logic                        wr_vld,
  input  logic [DATA_W-1:0]           wr_data,
  input  logic                        wr_eop,
  output logic                        out_vld,
  input  logic                        out_rdy,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_first,
  output logic                        out_last,
  output logic                        out_page_first,
  output logic                        out_err,
  output logic                        hdr_vld,
  output logic [PORT_W-1:0]           hdr_port,
  output logic [PRI_W-1:0]            hdr_prior,
  output logic [LEN_W-1:0]            hdr_len,
  output logic                        err_len,
  output logic                        err_ovf,
  output logic [$clog2(FIFO_DEPTH):0] fifo_cnt,
  output ingress_state_t              state_dbg
);

  localparam int IDX_W = LEN_W + 1;
  localparam int PG_W  = $clog2(PAGE_WORDS);
  localparam int HDR_W = LEN_W + PRI_W + PORT_W;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              first;
    logic              last;
    logic              page_first;
    logic              err;
  } entry_t;

  typedef struct packed {
    logic [LEN_W-1:0]  len;
    logic [PRI_W-1:0]  prior;
    logic [PORT_W-1:0] port;
  } hdr_t;

  ingress_state_t   state, state_nxt;
  entry_t           hold, hold_nxt, new_entry, push_entry, fifo_head;
  logic             hold_vld, hold_vld_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             push, fifo_full, space, beat_new;
  logic             ovf, hdr_cap, len_bad, len_err;
  hdr_t             hdr_in;

  assign hdr_in    = hdr_t'(wr_data[HDR_W-1:0]);
  assign beat_new  = wr_vld && ((state == ST_HEAD) || (state == ST_BODY));
  // When full, out_vld is high, so out_rdy means a pop frees a slot this cycle.
  assign space     = !fifo_full || out_rdy;
  assign state_dbg = state;

`ifdef INGRESS_LEN_CHECK_EN
  assign len_bad = ((idx - IDX_W'(1)) != {1'b0, hdr_len});
`else
  assign len_bad = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // FSM next state: sop always restarts framing; overflow diverts to DROP.
  always_comb begin
    state_nxt = state;
    if (wr_sop) begin
      state_nxt = ST_HEAD;
    end else begin
      case (state)
        ST_HEAD: if (wr_vld) state_nxt = ovf ? ST_DROP : ST_BODY;
        ST_BODY: begin
          if (wr_eop)              state_nxt = ST_IDLE;
          else if (wr_vld && ovf)  state_nxt = ST_DROP;
        end
        ST_DROP: if (wr_eop) state_nxt = ST_IDLE;
        default: ;
      endcase
    end
  end

  // Hold/push control: decides what leaves hold, what enters it, and errors.
  always_comb begin
    hold_nxt             = hold;
    hold_vld_nxt         = hold_vld;
    push                 = 1'b0;
    push_entry           = hold;
    ovf                  = 1'b0;
    hdr_cap              = 1'b0;
    len_err              = 1'b0;
    idx_nxt              = idx;
    new_entry.data       = wr_data;
    new_entry.first      = (state == ST_HEAD);
    new_entry.last       = 1'b0;
    new_entry.page_first = (state == ST_HEAD) || (idx[PG_W-1:0] == '0);
    new_entry.err        = 1'b0;
    if (wr_sop && (state == ST_BODY)) begin
      // Abort: the packet in flight ends on the beat sitting in hold.
      push_entry.last = 1'b1;
      push_entry.err  = 1'b1;
      if (space) begin
        push         = 1'b1;
        hold_vld_nxt = 1'b0;
      end else begin
        hold_nxt = push_entry;
      end
    end else if (wr_eop && (state == ST_BODY)) begin
      push_entry.last = 1'b1;
      push_entry.err  = hold.err | len_bad;
      len_err         = len_bad;
      if (space) begin
        push         = 1'b1;
        hold_vld_nxt = 1'b0;
      end else begin
        hold_nxt     = push_entry;
        hold_nxt.err = 1'b1;
        ovf          = 1'b1;
      end
    end else if (beat_new) begin
      if (hold_vld && !space) begin
        // No room for hold: drop the new beat and terminate what is held.
        // For a header this is the hold-busy case and drops the whole packet.
        hold_nxt.last = 1'b1;
        hold_nxt.err  = 1'b1;
        ovf           = 1'b1;
      end else begin
        push         = hold_vld;
        hold_nxt     = new_entry;
        hold_vld_nxt = 1'b1;
        hdr_cap      = (state == ST_HEAD);
        if (state == ST_HEAD) idx_nxt = IDX_W'(1);
        else if (!(&idx))     idx_nxt = idx + 1'b1;
      end
    end else if (hold_vld && hold.last && space) begin
      // Background drain of a terminated entry left in hold.
      push         = 1'b1;
      hold_vld_nxt = 1'b0;
    end
  end

  // Hold register, beat index, header fields and status pulses.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      hold      <= '0;
      hold_vld  <= 1'b0;
      idx       <= '0;
      hdr_vld   <= 1'b0;
      hdr_port  <= '0;
      hdr_prior <= '0;
      hdr_len   <= '0;
      err_len   <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      hold     <= hold_nxt;
      hold_vld <= hold_vld_nxt;
      idx      <= idx_nxt;
      hdr_vld  <= hdr_cap;
      err_len  <= len_err;
      err_ovf  <= ovf;
      if (hdr_cap) begin
        hdr_port  <= hdr_in.port;
        hdr_prior <= hdr_in.prior;
        hdr_len   <= hdr_in.len;
      end
    end
  end

  ingress_fifo #(
    .entry_t (entry_t),
    .DEPTH   (FIFO_DEPTH)
  ) u_fifo (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .push       (push),
    .push_entry (push_entry),
    .pop_rdy    (out_rdy),
    .full       (fifo_full),
    .head_vld   (out_vld),
    .head       (fifo_head),
    .cnt        (fifo_cnt)
  );

  assign out_data       = fifo_head.data;
  assign out_first      = fifo_head.first;
  assign out_last       = fifo_head.last;
  assign out_page_first = fifo_head.page_first;
  assign out_err        = fifo_head.err;

endmodule

// File: doc/ingress_framer.md
# ingress_framer

Parametrised ingress front end for one switch write port. It turns the raw `wr_sop`/`wr_vld`/`wr_eop` beat stream into framed, page-tagged entries in a small FIFO with a valid/ready handshake toward the page writer. It extracts the header fields (dest port, priority, length), checks the declared length, and cleanly terminates packets that overflow or are aborted. It sits between the port pins and the SRAM page allocator.

## Interface
- `DATA_W`, 16: beat width; header fields occupy the low `LEN_W+PRI_W+PORT_W` bits.
- `PORT_W`, 4: dest port field, bits [PORT_W-1:0].
- `PRI_W`, 3: priority field, next bits up.
- `LEN_W`, 9: length field, next bits up.
- `PAGE_WORDS`, 8: beats per SRAM page; power of two, ≥2.
- `FIFO_DEPTH`, 4: output FIFO entries; power of two, ≥2.

Ports:
- `sys_clk` in 1: the single clock.
- `sys_rst` in 1: asynchronous, active-high reset.
- `wr_sop` in 1: one-cycle pulse one cycle before the header beat.
- `wr_vld` in 1: beat valid; never high in the same cycle as `wr_sop` or `wr_eop`.
- `wr_data` in DATA_W: beat data.
- `wr_eop` in 1: one-cycle pulse after the last beat.
- `out_vld` out 1: FIFO head valid (first-word fall-through).
- `out_rdy` in 1: pop when `out_vld & out_rdy`.
- `out_data` out DATA_W: beat data.
- `out_first`, `out_last`, `out_page_first`, `out_err` out 1 each: entry tags.
- `hdr_vld` out 1: one-cycle pulse on header capture.
- `hdr_port` out PORT_W, `hdr_prior` out PRI_W, `hdr_len` out LEN_W: registered header fields, held until the next header.
- `err_len` out 1: pulse on length mismatch.
- `err_ovf` out 1: pulse on each packet dropped or truncated.
- `fifo_cnt` out log2(FIFO_DEPTH)+1: occupancy.

## Operation
- FSM states: IDLE, HEAD, BODY, DROP. `wr_sop` takes any state to HEAD. The first `wr_vld` in HEAD is the header and moves the FSM to BODY. `wr_eop` in BODY or DROP returns it to IDLE.
- Beat index counter: 0 on the header, incremented per accepted beat, LEN_W+1 bits wide, saturating. `page_first = (index mod PAGE_WORDS == 0)`.
- One-entry hold register. Each beat waits in hold until the next beat or `wr_eop` arrives, so the final beat can be tagged `last`.
- On a new beat, hold is pushed to the FIFO and the new beat enters hold. On `wr_eop`, hold is pushed with `last=1`.
- Length check: at `wr_eop`, payload beats (index−1) must equal `hdr_len`. On mismatch the last entry gets `err=1` and `err_len` pulses.
- Overflow: a push is needed but the FIFO is full and not popping in that cycle.
  - The incoming beat is discarded.
  - Hold is retagged `last=1, err=1` and drains when space frees.
  - The FSM enters DROP, `err_ovf` pulses once, and input beats are discarded until `wr_eop`.
- Abort: `wr_sop` while in BODY tags hold `last=1, err=1`.
- Hold busy: a header arriving while hold still holds an undrained terminated entry drops that whole packet.
  - `err_ovf` pulses, no `hdr_vld` is issued, and the FSM enters DROP.
- A `wr_vld` in IDLE is ignored.
- Every accepted packet therefore produces exactly one `first` entry and exactly one `last` entry.

## Timing
- Header beat at cycle t → `hdr_vld` and the header fields update at t+1.
- A beat is in the FIFO at the edge after its successor beat or `wr_eop`. `out_vld` rises in that same cycle.
- Push when full is allowed if a pop occurs in the same cycle.
- Reset values: FSM IDLE, hold empty, FIFO empty, `fifo_cnt`=0. All outputs are 0, including `hdr_*`.
- Reset mid-packet discards all state immediately; no `last` is emitted.

## Configuration
- `INGRESS_LEN_CHECK_EN` defined: the length check and `err_len` are active as described above.
- `INGRESS_LEN_CHECK_EN` undefined: no length comparison is made, `err_len` is tied to 0, and `err` is set only by overflow or abort.

## Structure
- Package `ingress_pkg`:
  - header struct typedef (`len`, `prior`, `port`);
  - FIFO entry struct (`data`, `first`, `last`, `page_first`, `err`);
  - FSM state enum;
  - default width constants.
- Sub-module `ingress_fifo`: synchronous FWFT FIFO parametrised by entry type and depth, with simultaneous push/pop support.

## Test plan
- Header 0x0235 (len=4, prior=3, port=5) plus 4 payload beats, `out_rdy`=1:
  - `hdr_vld` at t+1 with port 5, prior 3, len 4;
  - 5 entries, `first` on the 1st, `last` on the 5th, `page_first` only on the 1st, no errors.
- len=10, 11 beats total, PAGE_WORDS=8 → `page_first` on entries 0 and 8.
- Header declares len=4, only 3 payload beats sent → last entry `err=1`, one `err_len` pulse.
  - Repeat with the macro undefined → no error.
- `out_rdy`=0 and an 8-beat packet, FIFO_DEPTH=4:
  - 4 entries stored, hold retagged last+err, `err_ovf` once;
  - after `out_rdy`=1, exactly 5 entries drain, the 5th with `last=1, err=1`.
- `wr_sop` mid-BODY after 2 payload beats → previous packet ends `last=1, err=1`, and the new packet frames normally.
- Assert `sys_rst` mid-packet → `out_vld`=0 and `fifo_cnt`=0 immediately; a following clean packet passes intact.
